// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and address-split helper for the I-cache refill engine.
package icache_refill_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInval,
    StReq,
    StFill,
    StCommit
  } refill_state_e;

  // Extract a right-aligned bit field from an address; callers cast to the field width.
  function automatic logic [63:0] addr_field(input logic [63:0] addr, input int unsigned lsb,
                                             input int unsigned width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Bundle of miss, AXI burst, read-beat, data-RAM, tag-RAM and CPU-response signals.
interface icache_refill_ctrl_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned BeatWidth = 64,
  parameter int unsigned LineBeats = 4,
  parameter int unsigned NumSets   = 256,
  parameter int unsigned NumWays   = 4
);
  localparam int unsigned BeatOffW = $clog2(BeatWidth / 8);
  localparam int unsigned BeatIdxW = $clog2(LineBeats);
  localparam int unsigned IndexW   = $clog2(NumSets);
  localparam int unsigned TagW     = AddrWidth - IndexW - BeatIdxW - BeatOffW;
  localparam int unsigned WayW     = $clog2(NumWays);

  logic                       miss_valid_i;
  logic                       miss_ready_o;
  logic [AddrWidth-1:0]       miss_addr_i;
  logic [WayW-1:0]            miss_way_i;
  logic                       axi_valid_o;
  logic                       axi_ready_i;
  logic [AddrWidth-1:0]       axi_addr_o;
  logic                       beat_valid_i;
  logic                       beat_ready_o;
  logic [BeatWidth-1:0]       beat_data_i;
  logic                       beat_error_i;
  logic                       beat_last_i;
  logic [NumWays-1:0]         mem_en_o;
  logic [BeatWidth/8-1:0]     mem_we_o;
  logic [IndexW+BeatIdxW-1:0] mem_addr_o;
  logic [BeatWidth-1:0]       mem_din_o;
  logic                       tag_we_o;
  logic [WayW-1:0]            tag_way_o;
  logic [IndexW-1:0]          tag_index_o;
  logic [TagW-1:0]            tag_o;
  logic                       tag_valid_o;
  logic                       res_valid_o;
  logic                       res_ready_i;
  logic [BeatWidth-1:0]       res_data_o;
  logic                       res_error_o;

  modport master (
    input  miss_valid_i, miss_addr_i, miss_way_i, axi_ready_i, beat_valid_i, beat_data_i,
           beat_error_i, beat_last_i, res_ready_i,
    output miss_ready_o, axi_valid_o, axi_addr_o, beat_ready_o, mem_en_o, mem_we_o, mem_addr_o,
           mem_din_o, tag_we_o, tag_way_o, tag_index_o, tag_o, tag_valid_o, res_valid_o,
           res_data_o, res_error_o
  );

  modport slave (
    output miss_valid_i, miss_addr_i, miss_way_i, axi_ready_i, beat_valid_i, beat_data_i,
           beat_error_i, beat_last_i, res_ready_i,
    input  miss_ready_o, axi_valid_o, axi_addr_o, beat_ready_o, mem_en_o, mem_we_o, mem_addr_o,
           mem_din_o, tag_we_o, tag_way_o, tag_index_o, tag_o, tag_valid_o, res_valid_o,
           res_data_o, res_error_o
  );

endinterface

// File: rtl/icache_refill_resp_reg.sv
// One-entry valid/ready holding register for the forwarded critical beat.
module icache_refill_resp_reg #(
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic                 in_error_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_error_o
);

  logic                 valid_q;
  logic [DataWidth-1:0] data_q;
  logic                 error_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else if (in_valid_i) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
      error_q <= in_error_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_error_o = error_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache line refill engine: invalidate victim tag, wrapping burst fetch into banked
// data RAM, forward the critical beat to the CPU, then commit the tag.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned BeatWidth = 64,
  parameter int unsigned LineBeats = 4,
  parameter int unsigned NumSets   = 256,
  parameter int unsigned NumWays   = 4
) (
  input logic                 clk,
  input logic                 rst,
  icache_refill_ctrl_if.master bus
);

  localparam int unsigned BeatOffW = $clog2(BeatWidth / 8);
  localparam int unsigned BeatIdxW = $clog2(LineBeats);
  localparam int unsigned IndexW   = $clog2(NumSets);
  localparam int unsigned TagW     = AddrWidth - IndexW - BeatIdxW - BeatOffW;
  localparam int unsigned WayW     = $clog2(NumWays);

  refill_state_e        state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [WayW-1:0]      way_q;
  logic [BeatIdxW-1:0]  cnt_q;
  logic                 err_q;

  logic [IndexW-1:0]   index;
  logic [TagW-1:0]     tag;
  logic [BeatIdxW-1:0] crit;
  logic                beat_hs;
  logic                last_cnt;
  logic                res_valid;

  assign crit  = BeatIdxW'(addr_field(64'(addr_q), BeatOffW, BeatIdxW));
  assign index = IndexW'(addr_field(64'(addr_q), BeatOffW + BeatIdxW, IndexW));
  assign tag   = TagW'(addr_field(64'(addr_q), BeatOffW + BeatIdxW + IndexW, TagW));

  assign beat_hs  = (state_q == StFill) && bus.beat_valid_i;
  assign last_cnt = (cnt_q == BeatIdxW'(LineBeats - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.miss_valid_i && bus.miss_ready_o) begin
            addr_q  <= bus.miss_addr_i;
            way_q   <= bus.miss_way_i;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= StInval;
          end
        end
        StInval: state_q <= StReq;
        StReq: begin
          if (bus.axi_ready_i) begin
            cnt_q   <= '0;
            state_q <= StFill;
          end
        end
        StFill: begin
          if (bus.beat_valid_i) begin
            // The counter decides line end; a misplaced last marker only poisons the line.
            err_q <= err_q | bus.beat_error_i | (bus.beat_last_i != last_cnt);
            cnt_q <= cnt_q + 1'b1;
            if (last_cnt) state_q <= StCommit;
          end
        end
        StCommit: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign bus.miss_ready_o = (state_q == StIdle) && !res_valid;
  assign bus.axi_valid_o  = (state_q == StReq);
  assign bus.axi_addr_o   = bus.axi_valid_o ? {addr_q[AddrWidth-1:BeatOffW], {BeatOffW{1'b0}}}
                                            : '0;
  assign bus.beat_ready_o = (state_q == StFill);

  assign bus.mem_en_o   = beat_hs ? (NumWays'(1) << way_q) : '0;
  assign bus.mem_we_o   = beat_hs ? '1 : '0;
  assign bus.mem_addr_o = beat_hs ? {index, BeatIdxW'(crit + cnt_q)} : '0;
  assign bus.mem_din_o  = beat_hs ? bus.beat_data_i : '0;

  assign bus.tag_we_o    = (state_q == StInval) || (state_q == StCommit);
  assign bus.tag_way_o   = bus.tag_we_o ? way_q : '0;
  assign bus.tag_index_o = bus.tag_we_o ? index : '0;
  assign bus.tag_o       = bus.tag_we_o ? tag : '0;
  assign bus.tag_valid_o = (state_q == StCommit) && !err_q;

  icache_refill_resp_reg #(
    .DataWidth(BeatWidth)
  ) u_resp (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (beat_hs && (cnt_q == '0)),
    .in_data_i  (bus.beat_data_i),
    .in_error_i (bus.beat_error_i),
    .out_valid_o(res_valid),
    .out_ready_i(bus.res_ready_i),
    .out_data_o (bus.res_data_o),
    .out_error_o(bus.res_error_o)
  );

  assign bus.res_valid_o = res_valid;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: stimulus queues expected events, a negedge
// monitor pops and compares whenever the DUT presents a tag write, burst, RAM write or response.
module tb_icache_refill_ctrl;

  typedef struct packed {
    logic [1:0]  way;
    logic [7:0]  idx;
    logic [18:0] tag;
    logic        valid;
  } tag_exp_t;

  typedef struct packed {
    logic [3:0]  en;
    logic [7:0]  we;
    logic [9:0]  addr;
    logic [63:0] din;
  } mem_exp_t;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } res_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;

  tag_exp_t    exp_tag[$];
  logic [31:0] exp_axi[$];
  mem_exp_t    exp_mem[$];
  res_exp_t    exp_res[$];

  always #5 clk = ~clk;

  icache_refill_ctrl_if bus ();

  icache_refill_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    tests++;
    failed++;
    $display("FAIL %s unexpected event actual=%0h required=none", name, act);
  endtask

  tag_exp_t te;
  mem_exp_t me;
  res_exp_t re;
  logic [31:0] ae;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tag_we_o) begin
        if (exp_tag.size() == 0) unexpected("tag_write", {bus.tag_way_o, bus.tag_index_o});
        else begin
          te = exp_tag.pop_front();
          check("tag_write", {bus.tag_way_o, bus.tag_index_o, bus.tag_o, bus.tag_valid_o}, te);
        end
      end
      if (bus.axi_valid_o && bus.axi_ready_i) begin
        if (exp_axi.size() == 0) unexpected("axi_req", bus.axi_addr_o);
        else begin
          ae = exp_axi.pop_front();
          check("axi_addr", bus.axi_addr_o, ae);
        end
      end
      if (bus.beat_valid_i && bus.beat_ready_o) begin
        if (exp_mem.size() == 0) unexpected("mem_write", bus.mem_addr_o);
        else begin
          me = exp_mem.pop_front();
          check("mem_write", {bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_din_o}, me);
        end
      end else begin
        check("mem_en_idle", bus.mem_en_o, 4'b0000);
      end
      if (bus.res_valid_o && bus.res_ready_i) begin
        if (exp_res.size() == 0) unexpected("res", bus.res_data_o);
        else begin
          re = exp_res.pop_front();
          check("res_beat", {bus.res_data_o, bus.res_error_o}, re);
        end
      end
    end
  end

  // One refill: queue expected events, then drive the miss and the read beats.
  task automatic do_miss(input logic [31:0] addr, input logic [1:0] way, input logic [3:0] errmask,
                         input int last_at, input int gap_before, input bit hold_res,
                         input int abort_after);
    logic [7:0]  idx;
    logic [18:0] tag;
    logic [1:0]  crit;
    logic [63:0] d[4];
    logic        err;
    int          nb;
    int          guard;
    idx  = addr[12:5];
    tag  = addr[31:13];
    crit = addr[4:3];
    for (int k = 0; k < 4; k++) d[k] = {addr, 32'hBEEF_0000 + 32'(k)};
    nb  = (abort_after > 0) ? abort_after : 4;
    err = (|errmask) || (last_at != 3);
    exp_tag.push_back('{way, idx, tag, 1'b0});
    exp_axi.push_back({addr[31:3], 3'b000});
    for (int k = 0; k < nb; k++)
      exp_mem.push_back('{4'b0001 << way, 8'hFF, {idx, 2'(crit + 2'(k))}, d[k]});
    if (abort_after == 0) begin
      exp_res.push_back('{d[0], errmask[0]});
      exp_tag.push_back('{way, idx, tag, !err});
    end
    if (hold_res) bus.res_ready_i = 1'b0;

    guard = 0;
    while (!bus.miss_ready_o && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("miss_ready_wait", bus.miss_ready_o, 1'b1);
    bus.miss_valid_i = 1'b1;
    bus.miss_addr_i  = addr;
    bus.miss_way_i   = way;
    @(posedge clk);
    #1;
    bus.miss_valid_i = 1'b0;

    for (int k = 0; k < nb; k++) begin
      if (k == gap_before && k != 0) begin
        bus.beat_valid_i = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.beat_valid_i = 1'b1;
      bus.beat_data_i  = d[k];
      bus.beat_error_i = errmask[k];
      bus.beat_last_i  = (k == last_at);
      guard = 0;
      while (!bus.beat_ready_o && guard < 50) begin
        @(posedge clk);
        #1;
        guard++;
      end
      check("beat_ready_wait", bus.beat_ready_o, 1'b1);
      @(posedge clk);
      #1;
    end
    bus.beat_valid_i = 1'b0;
    bus.beat_error_i = 1'b0;
    bus.beat_last_i  = 1'b0;

    if (abort_after > 0) begin
      check("pre_abort_res_valid", bus.res_valid_o, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_res_valid", bus.res_valid_o, 1'b0);
      check("abort_miss_ready", bus.miss_ready_o, 1'b1);
      check("abort_tag_we", bus.tag_we_o, 1'b0);
      check("abort_beat_ready", bus.beat_ready_o, 1'b0);
      bus.res_ready_i = 1'b1;
    end else if (hold_res) begin
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        check("hold_miss_ready", bus.miss_ready_o, 1'b0);
      end
      check("hold_res_valid", bus.res_valid_o, 1'b1);
      bus.res_ready_i = 1'b1;
    end
  endtask

  initial begin
    bus.miss_valid_i = 1'b0;
    bus.miss_addr_i  = '0;
    bus.miss_way_i   = '0;
    bus.axi_ready_i  = 1'b1;
    bus.beat_valid_i = 1'b0;
    bus.beat_data_i  = '0;
    bus.beat_error_i = 1'b0;
    bus.beat_last_i  = 1'b0;
    bus.res_ready_i  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_miss_ready", bus.miss_ready_o, 1'b1);
    check("rst_axi_valid", bus.axi_valid_o, 1'b0);
    check("rst_beat_ready", bus.beat_ready_o, 1'b0);
    check("rst_mem_en", bus.mem_en_o, 4'b0000);
    check("rst_tag_we", bus.tag_we_o, 1'b0);
    check("rst_res_valid", bus.res_valid_o, 1'b0);
    rst = 1'b0;

    // Critical beat 3: wraps 3,0,1,2 into bank 2.
    do_miss(32'h0000_1238, 2'd2, 4'b0000, 3, 0, 1'b0, 0);
    // Error on beat 2 with a bus gap: line drained, never valid, critical beat clean.
    do_miss(32'hABCD_E010, 2'd1, 4'b0100, 3, 2, 1'b0, 0);
    // CPU stalls the response: engine finishes but stays busy until the handshake.
    do_miss(32'h0000_2000, 2'd0, 4'b0000, 3, 0, 1'b1, 0);
    // Early last marker: line invalid at commit.
    do_miss(32'h8765_4328, 2'd3, 4'b0000, 1, 0, 1'b0, 0);
    // Reset after two beats while the response is still pending.
    do_miss(32'h0000_1FF8, 2'd1, 4'b0000, 3, 0, 1'b1, 2);
    // Clean refill after the abort.
    do_miss(32'hFFFF_FFF0, 2'd0, 4'b0000, 3, 0, 1'b0, 0);

    repeat (6) @(posedge clk);
    #1;
    check("tag_queue_empty", 32'(exp_tag.size()), 32'd0);
    check("axi_queue_empty", 32'(exp_axi.size()), 32'd0);
    check("mem_queue_empty", 32'(exp_mem.size()), 32'd0);
    check("res_queue_empty", 32'(exp_res.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
